// File: rtl/adc_capture_avmm_if.sv
// Avalon-MM register bus of the ADC capture engine (2-bit word address,
// 32-bit data, read latency 1).
interface adc_capture_avmm_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/adc_capture_avmm.sv
// ADC capture engine: divided sample clock, optional threshold trigger,
// N-sample capture into an on-chip FIFO drained through an Avalon-MM
// DATA register, and a level interrupt on completion.
module adc_capture_avmm #(
  parameter int DATA_W     = 14,
  parameter int FIFO_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  adc_capture_avmm_if.slave avs,
  output logic              ad_clk,
  input  logic [DATA_W-1:0] ad_data,
  output logic              irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              trig_en, irq_en, done;
  logic [7:0]        div, div_cnt;
  logic [15:0]       len;
  logic [DATA_W-1:0] thresh, ad_q, prev;
  logic [LW-1:0]     cnt, cnt_inc, n_eff, level;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  // Bus decode. A read that collides with a write is answered with 0 and
  // must not pop, so pops only come from pure reads.
  logic wr_en, rd_sel, ctrl_wr, start_req, abort_req, done_clr_req;
  logic pop_en, push_en, last_push, fifo_empty, div_wrap, smp, trig_hit;

  assign wr_en        = avs.chipselect & avs.write;
  assign rd_sel       = avs.chipselect & avs.read;
  assign ctrl_wr      = wr_en && (avs.address == 2'd0);
  assign start_req    = ctrl_wr & avs.writedata[0];
  assign abort_req    = ctrl_wr & avs.writedata[1] & ~avs.writedata[0];
  assign done_clr_req = ctrl_wr & avs.writedata[4];
  assign fifo_empty   = (level == '0);
  assign pop_en       = rd_sel & ~avs.write & (avs.address == 2'd3) & ~fifo_empty;

  // Writedata bits with no register behind them.
  logic unused_wd;
  assign unused_wd = ^{avs.writedata[31:16], avs.writedata[7:5]};

  // Out-of-range or zero LEN means a full-FIFO capture.
  assign n_eff   = (len == 16'd0 || 32'(len) > FIFO_DEPTH) ? LW'(FIFO_DEPTH) : len[LW-1:0];
  assign cnt_inc = cnt + LW'(1);

  // The counter wraps as soon as it is at or above DIV, which also covers
  // DIV being lowered below the running count.
  assign div_wrap = (div_cnt >= div);
  assign smp      = div_wrap & ad_clk;
  assign trig_hit = smp && (prev < thresh) && (thresh <= ad_q);

  // Configuration registers written from the bus.
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update from the same pre-edge values; blocking ones would make
  // the result depend on process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_en <= 1'b0;
      irq_en  <= 1'b0;
      div     <= '0;
      len     <= '0;
      thresh  <= '0;
    end else if (wr_en) begin
      case (avs.address)
        2'd0: begin
          trig_en <= avs.writedata[2];
          irq_en  <= avs.writedata[3];
          div     <= avs.writedata[15:8];
        end
        2'd1:    len    <= avs.writedata[15:0];
        2'd2:    thresh <= avs.writedata[DATA_W-1:0];
        default: ;
      endcase
    end
  end

  // Sample clock divider and input register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      ad_clk  <= 1'b0;
      ad_q    <= '0;
    end else begin
      ad_q <= ad_data;
      if (div_wrap) begin
        div_cnt <= '0;
        ad_clk  <= ~ad_clk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

  // Capture FSM: state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Capture FSM: next state. START beats ABORT; the trigger mode comes from
  // the same CTRL write that carries START.
  always_comb begin
    state_nxt = state;
    if (start_req)      state_nxt = avs.writedata[2] ? S_ARMED : S_CAPTURE;
    else if (abort_req) state_nxt = S_IDLE;
    else if (push_en)   state_nxt = last_push ? S_DONE : S_CAPTURE;
  end

  // Capture FSM: outputs. The triggering sample is itself stored as sample 0.
  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    push_en = 1'b0;
    if (!start_req && !abort_req) begin
      case (state)
        S_ARMED:   push_en = trig_hit;
        S_CAPTURE: push_en = smp;
        default:   push_en = 1'b0;
      endcase
    end
    last_push = push_en && (cnt_inc == n_eff);
  end

  // Sample counter, trigger history and completion flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      prev <= '1;
      done <= 1'b0;
    end else begin
      if (start_req)    cnt <= '0;
      else if (push_en) cnt <= cnt_inc;

      // All-ones on arming, so the first strobe can never look like a crossing.
      if (start_req)                                    prev <= '1;
      else if (state == S_ARMED && smp && !abort_req)   prev <= ad_q;

      if (start_req)         done <= 1'b0;
      else if (last_push)    done <= 1'b1;
      else if (done_clr_req) done <= 1'b0;
    end
  end

  // FIFO pointers and fill level; START flushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (start_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage.
  // NOTE: the sample array has no reset; the pointers and level define which
  // entries are valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= ad_q;
  end

  // Registered read data (latency 1, holds until the next read).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs.readdata <= '0;
    end else if (rd_sel) begin
      if (avs.write) begin
        avs.readdata <= '0;
      end else begin
        case (avs.address)
          2'd0: avs.readdata <= {{(16-LW){1'b0}}, level, div, 4'b0000,
                                 (state == S_ARMED), fifo_empty, done,
                                 (state == S_ARMED) || (state == S_CAPTURE)};
          2'd1: avs.readdata <= {16'h0000, len};
          2'd2: avs.readdata <= {{(32-DATA_W){1'b0}}, thresh};
          default: avs.readdata <= fifo_empty ? 32'h0
                                 : {1'b1, {(31-DATA_W){1'b0}}, mem[rd_ptr]};
        endcase
      end
    end
  end

  // Registered level interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= done & irq_en;
  end

endmodule

// File: tb/tb_adc_capture_avmm.sv
// Self-checking bench for adc_capture_avmm: register table, directed capture
// sequences and a randomized phase, all compared cycle by cycle against a
// queue-based reference model of the capture engine.
module tb_adc_capture_avmm;
  localparam int DW    = 14;
  localparam int DEPTH = 16;
  localparam int ST_IDLE = 0, ST_ARMED = 1, ST_CAPTURE = 2, ST_DONE = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          ad_clk, irq;
  logic [DW-1:0] ad_data = '0;

  always #5 clk = ~clk;

  adc_capture_avmm_if bus ();

  adc_capture_avmm #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus),
    .ad_clk  (ad_clk),
    .ad_data (ad_data),
    .irq     (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [DW-1:0] m_q [$];
  int            m_state, m_cnt, m_div, m_div_cnt, m_len;
  logic [DW-1:0] m_prev, m_thresh;
  bit            m_done, m_irq_en, m_irq, m_ad_clk, m_fell;
  logic [31:0]   m_rdata;

  // ADC stimulus: a new word is presented after each ad_clk falling edge.
  logic [DW-1:0] m_cur = '0;
  logic [DW-1:0] feed_q [$];
  int            feed_mode = 0;   // 0 hold, 1 ramp, 2 random
  int            rand_max  = 63;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state = ST_IDLE; m_cnt = 0; m_div = 0; m_div_cnt = 0; m_len = 0;
    m_prev = '1; m_thresh = '0; m_done = 0; m_irq_en = 0; m_irq = 0;
    m_ad_clk = 0; m_fell = 0; m_rdata = '0;
  endtask

  // One clock of the reference model, evaluated from the bus inputs that
  // are about to be sampled and the model state before the edge.
  task automatic model_step();
    bit          wr, rd, smp, start, abort, dclr, push, last;
    logic [1:0]  a;
    logic [31:0] wd, rv;
    int          n;
    wr    = bus.chipselect && bus.write;
    rd    = bus.chipselect && bus.read;
    a     = bus.address;
    wd    = bus.writedata;
    smp   = (m_div_cnt >= m_div) && m_ad_clk;
    n     = (m_len == 0 || m_len > DEPTH) ? DEPTH : m_len;
    start = wr && a == 2'd0 && wd[0];
    abort = wr && a == 2'd0 && wd[1] && !wd[0];
    dclr  = wr && a == 2'd0 && wd[4];
    push  = 0;
    last  = 0;
    rv    = m_rdata;
    if (rd) begin
      if (wr) rv = 32'h0;
      else case (a)
        2'd0: rv = {16'(m_q.size()), 8'(m_div), 4'b0000, m_state == ST_ARMED, m_q.size() == 0,
                    m_done, m_state == ST_ARMED || m_state == ST_CAPTURE};
        2'd1: rv = 32'(m_len);
        2'd2: rv = 32'(m_thresh);
        default: begin
          if (m_q.size() > 0) rv = {1'b1, 17'b0, m_q.pop_front()};
          else                rv = 32'h0;
        end
      endcase
    end
    m_irq = m_done && m_irq_en;
    if (start) begin
      m_q.delete(); m_done = 0; m_cnt = 0; m_prev = '1;
      m_state = wd[2] ? ST_ARMED : ST_CAPTURE;
    end else if (abort) begin
      m_state = ST_IDLE;
    end else if (smp) begin
      if (m_state == ST_ARMED) begin
        push   = (m_prev < m_thresh) && (m_thresh <= m_cur);
        m_prev = m_cur;
      end else if (m_state == ST_CAPTURE) begin
        push = 1;
      end
    end
    if (push) begin
      m_q.push_back(m_cur);
      m_cnt++;
      last    = (m_cnt == n);
      m_state = last ? ST_DONE : ST_CAPTURE;
      if (last) m_done = 1;
    end
    if (dclr && !start && !last) m_done = 0;
    m_fell = 0;
    if (m_div_cnt >= m_div) begin
      m_div_cnt = 0;
      m_ad_clk  = !m_ad_clk;
      m_fell    = !m_ad_clk;
    end else begin
      m_div_cnt++;
    end
    if (wr) case (a)
      2'd0: begin m_irq_en = wd[3]; m_div = int'(wd[15:8]); end
      2'd1: m_len = int'(wd[15:0]);
      2'd2: m_thresh = wd[DW-1:0];
      default: ;
    endcase
    m_rdata = rv;
  endtask

  // Advance one clock, update the ADC word, compare every output.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (m_fell) begin
      if (feed_q.size() > 0) m_cur = feed_q.pop_front();
      else if (feed_mode == 1) m_cur = m_cur + 1'b1;
      else if (feed_mode == 2) m_cur = DW'($urandom_range(rand_max, 0));
    end
    ad_data = m_cur;
    check("readdata", bus.readdata, m_rdata);
    check("irq", 32'(irq), 32'(m_irq));
    check("ad_clk", 32'(ad_clk), 32'(m_ad_clk));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1; bus.write = 1; bus.read = 0; bus.address = a; bus.writedata = d;
    tick();
    bus.chipselect = 0; bus.write = 0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.chipselect = 1; bus.read = 1; bus.write = 0; bus.address = a;
    tick();
    d = bus.readdata;
    bus.chipselect = 0; bus.read = 0;
  endtask

  task automatic wait_done(input string name, input int limit);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < limit; i++) begin
      bus_read(2'd0, d);
      if (d[1]) break;
    end
    check(name, 32'(d[1]), 32'd1);
  endtask

  task automatic wait_level(input string name, input int lvl, input int limit, output int reads);
    logic [31:0] d;
    d = '0;
    reads = 0;
    for (int i = 0; i < limit; i++) begin
      bus_read(2'd0, d);
      reads++;
      if (int'(d[31:16]) == lvl) break;
    end
    check(name, 32'(d[31:16]), 32'(lvl));
  endtask

  task automatic wait_feed(input int limit);
    for (int i = 0; i < limit && feed_q.size() > 0; i++) tick();
    check("feed_drained", 32'(feed_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_ad_clk", 32'(ad_clk), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;   // write data, or expected read data
    string       name;
  } vec_t;

  initial begin
    vec_t          vecs [13];
    logic [31:0]   d, ctrl_base;
    logic [DW-1:0] exp_s [$];
    int            cyc, dv, r;
    bit            tg, ie;

    vecs[0]  = '{0, 2'd0, 32'h0000_0004, "status_reset"};
    vecs[1]  = '{0, 2'd1, 32'h0000_0000, "len_reset"};
    vecs[2]  = '{0, 2'd2, 32'h0000_0000, "thresh_reset"};
    vecs[3]  = '{0, 2'd3, 32'h0000_0000, "data_empty"};
    vecs[4]  = '{1, 2'd1, 32'hABCD_1234, "wr_len"};
    vecs[5]  = '{0, 2'd1, 32'h0000_1234, "len_readback"};
    vecs[6]  = '{1, 2'd2, 32'hFFFF_FFFF, "wr_thresh"};
    vecs[7]  = '{0, 2'd2, 32'h0000_3FFF, "thresh_masked"};
    vecs[8]  = '{1, 2'd0, 32'h0000_0500, "wr_div5"};
    vecs[9]  = '{0, 2'd0, 32'h0000_0504, "status_div5"};
    vecs[10] = '{1, 2'd0, 32'h0000_0000, "wr_div0"};
    vecs[11] = '{1, 2'd2, 32'h0000_0000, "wr_thresh0"};
    vecs[12] = '{0, 2'd0, 32'h0000_0004, "status_idle"};

    bus.chipselect = 0; bus.read = 0; bus.write = 0; bus.address = '0; bus.writedata = '0;
    #2;
    do_reset();

    // Register table.
    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else begin
        bus_read(vecs[i].addr, d);
        check(vecs[i].name, d, vecs[i].data);
      end
    end

    // Read and write together: write happens, read returns 0.
    bus.chipselect = 1; bus.read = 1; bus.write = 1; bus.address = 2'd1; bus.writedata = 32'd7;
    tick();
    check("rw_collision", bus.readdata, 32'h0);
    bus.chipselect = 0; bus.read = 0; bus.write = 0;
    bus_read(2'd1, d);
    check("rw_collision_len", d, 32'd7);

    // Immediate capture of a ramp, DIV=0, LEN=4.
    feed_mode = 1;
    bus_write(2'd1, 32'd4);
    bus_write(2'd0, 32'h0000_0001);
    wait_done("imm_done", 100);
    exp_s = m_q;
    check("imm_model_len", 32'(exp_s.size()), 32'd4);
    for (int i = 0; i < 4 && i < exp_s.size(); i++) begin
      bus_read(2'd3, d);
      check($sformatf("imm_sample%0d", i), d, {1'b1, 17'b0, exp_s[i]});
      if (i > 0) check($sformatf("imm_ramp%0d", i), 32'(exp_s[i] - exp_s[i-1]), 32'd1);
    end
    bus_read(2'd3, d);
    check("imm_underflow", d, 32'h0);
    bus_read(2'd0, d);
    check("imm_status_done", 32'(d[2:0]), 32'b110);

    // Divider: DIV=3 -> 8-cycle ad_clk period and one push every 8 cycles.
    feed_mode = 0;
    bus_write(2'd0, 32'h0000_0300);
    begin
      bit p;
      for (int i = 0; i < 50; i++) begin p = ad_clk; tick(); if (!p && ad_clk) break; end
      cyc = 0;
      for (int i = 0; i < 50; i++) begin p = ad_clk; tick(); cyc++; if (!p && ad_clk) break; end
      check("ad_clk_period", 32'(cyc), 32'd8);
    end
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'h0000_0301);
    wait_level("div_level1", 1, 60, cyc);
    wait_level("div_level2", 2, 60, cyc);
    check("push_spacing", 32'(cyc), 32'd8);
    wait_done("div_done", 60);

    // Trigger on an upward crossing of 100.
    bus_write(2'd0, 32'h0000_0100);
    feed_q.push_back(DW'(50));
    wait_feed(40);
    idle(8);
    bus_write(2'd2, 32'd100);
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h0000_0105);
    bus_read(2'd0, d);
    check("trig_armed", 32'(d[3:0]), 32'b1101);
    feed_q = '{DW'(90), DW'(95), DW'(99)};
    wait_feed(40);
    idle(8);
    bus_read(2'd0, d);
    check("trig_still_armed", {d[31:16], 12'b0, d[3:0]}, 32'h0000_000D);
    feed_q = '{DW'(100), DW'(105)};
    wait_done("trig_done", 60);
    bus_read(2'd3, d);
    check("trig_first", d, 32'h8000_0064);
    bus_read(2'd3, d);
    check("trig_second", d, 32'h8000_0069);

    // Samples that start above the threshold never trigger.
    feed_q.push_back(DW'(150));
    wait_feed(40);
    idle(8);
    bus_write(2'd0, 32'h0000_0105);
    feed_q = '{DW'(120), DW'(130), DW'(200)};
    wait_feed(40);
    idle(20);
    bus_read(2'd0, d);
    check("no_trig", {d[31:16], 12'b0, d[3:0]}, 32'h0000_000D);
    bus_write(2'd0, 32'h0000_0102);

    // LEN boundaries: 0 and DEPTH+5 both capture DEPTH samples.
    feed_mode = 1;
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h0000_0001);
    wait_done("len0_done", 200);
    bus_read(2'd0, d);
    check("len0_level", 32'(d[31:16]), 32'(DEPTH));
    bus_write(2'd1, 32'(DEPTH + 5));
    bus_write(2'd0, 32'h0000_0001);
    wait_done("lenbig_done", 200);
    idle(20);
    bus_read(2'd0, d);
    check("lenbig_level", 32'(d[31:16]), 32'(DEPTH));
    repeat (DEPTH) bus_read(2'd3, d);
    bus_read(2'd3, d);
    check("lenbig_drained", d, 32'h0);

    // Interrupt, DONE_CLR, then ABORT after 3 samples.
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h0000_0009);
    wait_done("irq_done", 60);
    tick();
    check("irq_set", 32'(irq), 32'd1);
    bus_write(2'd0, 32'h0000_0018);
    tick();
    check("irq_cleared", 32'(irq), 32'd0);
    bus_write(2'd1, 32'd8);
    bus_write(2'd0, 32'h0000_0309);
    wait_level("abort_level3", 3, 100, cyc);
    bus_write(2'd0, 32'h0000_030A);
    idle(20);
    bus_read(2'd0, d);
    check("abort_status", {d[31:16], 12'b0, d[3:0]}, 32'h0003_0000);
    check("abort_irq", 32'(irq), 32'd0);

    // Restart from DONE flushes; then reset mid-capture.
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h0000_0001);
    wait_done("restart_done", 100);
    bus_read(2'd0, d);
    check("restart_level10", 32'(d[31:16]), 32'd10);
    bus_write(2'd0, 32'h0000_0701);
    bus_read(2'd0, d);
    check("restart_flushed", {d[31:16], 12'b0, d[3:0]}, 32'h0000_0005);
    idle(40);
    bus_read(2'd0, d);
    do_reset();
    bus_read(2'd0, d);
    check("post_reset_status", d, 32'h0000_0004);

    // Randomized traffic against the model.
    feed_mode = 2;
    rand_max  = 63;
    for (int it = 0; it < 40; it++) begin
      dv = $urandom_range(2, 0);
      tg = 1'($urandom_range(1, 0));
      ie = 1'($urandom_range(1, 0));
      ctrl_base = {16'h0, 8'(dv), 4'b0000, ie, tg, 2'b00};
      bus_write(2'd1, 32'($urandom_range(6, 0)));
      bus_write(2'd2, 32'($urandom_range(63, 0)));
      bus_write(2'd0, ctrl_base | 32'h1);
      for (int c = 0; c < 60; c++) begin
        r = $urandom_range(99, 0);
        if (r < 25)      bus_read(2'($urandom_range(3, 0)), d);
        else if (r < 29) bus_write(2'd0, ctrl_base | 32'h10);
        else if (r < 31) bus_write(2'd0, ctrl_base | 32'h2);
        else             tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
